relu_backward: RTL and testbench
================================

// Module: relu_backward
// PURPOSE
// - Backward-pass counterpart of the fixed-point ReLU activation: dx = (x > 0) ? dy : 0.
// - Forward side streams pre-activation x values in; the block stores only the 1-bit derivative mask per element in a mask FIFO.
// - Backward side streams upstream gradients dy in, in the same element order, and emits a width-converted masked gradient dx.
// - Sits between the activation layer and the preceding MAC layer's gradient path.
// PARAMETERS
// - M          8   forward x width (signed X_INTEGER.X_FRACTION)
// - X_INTEGER  3   x integer bits (incl. sign); X_FRACTION 5 x fraction bits
// - G_W        8   gradient-in width; G_INTEGER 3, G_FRACTION 5 (signed)
// - N          8   gradient-out width; Y_INTEGER 3, Y_FRACTION 5 (signed)
// - DEPTH      16  mask FIFO entries; power of 2, >= 2
// PORTS
// - clk         in   1                  clock
// - rst         in   1                  synchronous, active-high reset
// - fwd_valid   in   1                  x valid
// - fwd_ready   out  1                  mask FIFO can accept
// - fwd_x       in   M                  pre-activation value
// - grad_valid  in   1                  dy valid
// - grad_ready  out  1                  dy accepted this cycle when valid
// - grad_in     in   G_W                upstream gradient dy
// - dx_valid    out  1                  dx valid
// - dx_ready    in   1                  downstream accepts dx
// - dx          out  N                  masked, converted gradient
// - mask_count  out  $clog2(DEPTH+1)    masks stored
// - sat_flag    out  1                  present only with RELU_BWD_SAT_EN; dx was clamped
// BEHAVIOUR
// - Reset: fifo empty, mask_count=0, dx_valid=0, dx=0, sat_flag=0, fwd_ready=1, grad_ready=0.
// - Mask: mask = ~fwd_x[M-1] & (fwd_x != 0). Derivative at x == 0 is 0.
// - Push: on fwd_valid & fwd_ready. fwd_ready = (mask_count != DEPTH). No write-through when full, even if a pop occurs in the same cycle.
// - Pop and capture: grad_ready = (mask_count != 0) & (~dx_valid | dx_ready).
//   - On grad_valid & grad_ready, the head mask is popped, dx <= mask ? conv(grad_in) : 0, and dx_valid <= 1.
// - Latency: 1 cycle from dy handshake to dx_valid.
//   - With dx_ready held high, throughput is 1 element per cycle.
// - Hold: dx_valid & ~dx_ready keeps dx and sat_flag stable. dx_valid drops after a dx handshake with no new dy capture.
// - Simultaneous push and pop: mask_count unchanged. Pointers wrap modulo DEPTH.
// - Empty FIFO: grad_ready=0, so dy is stalled and never dropped.
// - conv:
//   - Align fraction. Arithmetic right shift by G_FRACTION-Y_FRACTION (truncate toward -inf), or left shift when that difference is negative.
//   - Then fit to N bits (see CONFIGURATION).
// - rst mid-operation: all stored masks are discarded and dx_valid clears on the next edge. No partial state survives.
// CONFIGURATION
// - Macro RELU_BWD_SAT_EN:
//   - Defined: conv clamps to [-2^(N-1), 2^(N-1)-1]. sat_flag=1 registered alongside dx when clamping occurred, else 0.
//   - Undefined: conv keeps the low N bits (two's-complement wrap). The sat_flag port does not exist.
// STRUCTURE
// - Package relu_pkg:
//   - typedef fxp_fmt_t {int integer_bits; int fraction_bits;}
//   - function fxp_convert() for shift/truncate/saturate
//   - localparam MASK_W = 1
// - Sub-module relu_mask_fifo (DEPTH x 1-bit, synchronous, count output). Top level holds the dx output register and the handshake logic.
// TESTING (DEPTH=4, all formats 3.5 unless noted)
// 1. Push x=0x20, 0xE0, 0x00. Send dy=0x10 three times -> dx=0x10, 0x00, 0x00, each 1 cycle after its handshake.
// 2. Push 4 masks with no dy -> mask_count=4, fwd_ready=0. A 5th push is held. Push+pop in the same cycle at count=2 -> count stays 2.
// 3. grad_valid=1 with empty FIFO -> grad_ready=0 and dx_valid stays 0. Then push x=0x01 -> dy accepted next cycle.
// 4. dx_ready=0 for 3 cycles with dx_valid=1, dx=0x10 -> dx stable, grad_ready=0. Release -> the next dy is accepted in the same cycle.
// 5. N=7, Y_INTEGER=2, dy=0x7F (3.97), mask=1:
//    - with RELU_BWD_SAT_EN -> dx=7'h3F, sat_flag=1
//    - without -> dx=7'h7F
// 6. rst for one cycle with mask_count=2 and dx_valid=1 -> next cycle mask_count=0, dx_valid=0, fwd_ready=1.

Source files
------------

// File: rtl/relu_pkg.sv
// Shared types and fixed-point helpers for the ReLU backward path.
package relu_pkg;

  localparam int MASK_W = 1;
  localparam int FXP_W  = 64;

  typedef struct packed {
    int integer_bits;
    int fraction_bits;
  } fxp_fmt_t;

  // Realign the binary point, then optionally clamp to the output format's range.
  // The caller keeps the low bits, which gives two's-complement wrap when unclamped.
  function automatic logic signed [FXP_W-1:0] fxp_convert(
    input  logic signed [FXP_W-1:0] v,
    input  fxp_fmt_t                in_fmt,
    input  fxp_fmt_t                out_fmt,
    input  bit                      sat_en,
    output logic                    sat
  );
    int                      shift;
    int                      w;
    logic signed [FXP_W-1:0] a;
    logic signed [FXP_W-1:0] hi;
    logic signed [FXP_W-1:0] lo;
    shift = in_fmt.fraction_bits - out_fmt.fraction_bits;
    if (shift >= 0) a = v >>> shift;
    else            a = v <<< (-shift);
    w   = out_fmt.integer_bits + out_fmt.fraction_bits;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (w - 1));
    sat = 1'b0;
    if (sat_en) begin
      if (a > hi) begin
        a   = hi;
        sat = 1'b1;
      end else if (a < lo) begin
        a   = lo;
        sat = 1'b1;
      end
    end
    return a;
  endfunction

endpackage

// File: rtl/relu_mask_fifo.sv
// DEPTH x MASK_W synchronous FIFO holding forward-pass derivative masks.
module relu_mask_fifo
  import relu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [MASK_W-1:0] din_i,
  input  logic              pop_i,
  output logic [MASK_W-1:0] dout_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0][MASK_W-1:0] mem_q;
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic                         do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // Full blocks a push even when a pop frees a slot in the same cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/relu_backward.sv
// ReLU backward: stores forward masks, emits dx = mask ? conv(dy) : 0.
// Build option RELU_BWD_SAT_EN: clamp conv to N bits and expose sat_flag.
module relu_backward
  import relu_pkg::*;
#(
  parameter int M          = 8,
  parameter int X_INTEGER  = 3,
  parameter int X_FRACTION = 5,
  parameter int G_W        = 8,
  parameter int G_INTEGER  = 3,
  parameter int G_FRACTION = 5,
  parameter int N          = 8,
  parameter int Y_INTEGER  = 3,
  parameter int Y_FRACTION = 5,
  parameter int DEPTH      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fwd_valid,
  output logic                       fwd_ready,
  input  logic [M-1:0]               fwd_x,
  input  logic                       grad_valid,
  output logic                       grad_ready,
  input  logic [G_W-1:0]             grad_in,
  output logic                       dx_valid,
  input  logic                       dx_ready,
  output logic [N-1:0]               dx,
  output logic [$clog2(DEPTH+1)-1:0] mask_count
`ifdef RELU_BWD_SAT_EN
  ,
  output logic                       sat_flag
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam fxp_fmt_t IN_FMT  = '{integer_bits: G_INTEGER, fraction_bits: G_FRACTION};
  localparam fxp_fmt_t OUT_FMT = '{integer_bits: Y_INTEGER, fraction_bits: Y_FRACTION};
`ifdef RELU_BWD_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic                    push, pop;
  logic [MASK_W-1:0]       mask_in, mask_head;
  logic                    fifo_full, fifo_empty;
  logic [CNT_W-1:0]        count;
  logic signed [FXP_W-1:0] g_ext, conv_full;
  logic                    conv_sat;
  logic [N-1:0]            dx_q, dx_d;
  logic                    dx_valid_q, dx_valid_d;
  logic                    sat_d;
  logic                    unused_bits;

  // Zero is treated as non-positive, so its derivative is 0.
  assign mask_in = MASK_W'(~fwd_x[M-1] & (|fwd_x));

  assign fwd_ready  = (count != FULL_CNT);
  assign grad_ready = (count != '0) & (~dx_valid_q | dx_ready);
  assign push       = fwd_valid & fwd_ready;
  assign pop        = grad_valid & grad_ready;

  relu_mask_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (mask_in),
    .pop_i   (pop),
    .dout_o  (mask_head),
    .count_o (count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign g_ext = {{(FXP_W-G_W){grad_in[G_W-1]}}, grad_in};

  always_comb begin
    conv_sat  = 1'b0;
    conv_full = fxp_convert(g_ext, IN_FMT, OUT_FMT, SAT_EN, conv_sat);
  end

  always_comb begin
    dx_d       = dx_q;
    dx_valid_d = dx_valid_q;
    sat_d      = 1'b0;
    if (pop) begin
      dx_valid_d = 1'b1;
      dx_d       = mask_head[0] ? conv_full[N-1:0] : '0;
      sat_d      = mask_head[0] & conv_sat;
    end else if (dx_ready) begin
      dx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dx_q       <= '0;
      dx_valid_q <= 1'b0;
    end else begin
      dx_q       <= dx_d;
      dx_valid_q <= dx_valid_d;
    end
  end

`ifdef RELU_BWD_SAT_EN
  logic sat_q;
  always_ff @(posedge clk) begin
    if (rst)      sat_q <= 1'b0;
    else if (pop) sat_q <= sat_d;
  end
  assign sat_flag = sat_q;
`endif

  assign dx         = dx_q;
  assign dx_valid   = dx_valid_q;
  assign mask_count = count;

  // Upper conversion bits and FIFO flags are intentionally not consumed here.
  assign unused_bits = ^{conv_full[FXP_W-1:N], conv_sat, sat_d, fifo_full, fifo_empty};

endmodule

// File: tb/tb_relu_backward.sv
// Scoreboard bench for relu_backward (DEPTH=4) plus an N=7 instance for conversion.
module tb_relu_backward;

  logic       clk = 1'b0;
  logic       rst;
  logic       fwd_valid, fwd_ready;
  logic [7:0] fwd_x;
  logic       grad_valid, grad_ready;
  logic [7:0] grad_in;
  logic       dx_valid, dx_ready;
  logic [7:0] dx;
  logic [2:0] mask_count;
`ifdef RELU_BWD_SAT_EN
  logic       sat_flag;
  logic       b_sat_flag;
`endif

  logic       b_fwd_valid, b_fwd_ready;
  logic [7:0] b_fwd_x;
  logic       b_grad_valid, b_grad_ready;
  logic [7:0] b_grad_in;
  logic       b_dx_valid, b_dx_ready;
  logic [6:0] b_dx;
  logic [2:0] b_mask_count;

  int tests = 0;
  int fails = 0;
  bit maskq[$];
  logic [7:0] expq[$];

  always #5 clk = ~clk;

  relu_backward #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_x(fwd_x),
    .grad_valid(grad_valid), .grad_ready(grad_ready), .grad_in(grad_in),
    .dx_valid(dx_valid), .dx_ready(dx_ready), .dx(dx),
    .mask_count(mask_count)
`ifdef RELU_BWD_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  relu_backward #(.N(7), .Y_INTEGER(2), .Y_FRACTION(5), .DEPTH(4)) dut7 (
    .clk(clk), .rst(rst),
    .fwd_valid(b_fwd_valid), .fwd_ready(b_fwd_ready), .fwd_x(b_fwd_x),
    .grad_valid(b_grad_valid), .grad_ready(b_grad_ready), .grad_in(b_grad_in),
    .dx_valid(b_dx_valid), .dx_ready(b_dx_ready), .dx(b_dx),
    .mask_count(b_mask_count)
`ifdef RELU_BWD_SAT_EN
    , .sat_flag(b_sat_flag)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit mask_of(input logic [7:0] x);
    return (x[7] == 1'b0) && (x != 8'h00);
  endfunction

  // One clock: drive, sample readiness mid-cycle, update the model, cross the edge.
  task automatic cyc(input bit fv, input logic [7:0] x, input bit gv, input logic [7:0] dy,
                     output bit fa, output bit ga);
    bit m;
    fwd_valid = fv; fwd_x = x; grad_valid = gv; grad_in = dy;
    @(negedge clk);
    fa = fv && (fwd_ready === 1'b1);
    ga = gv && (grad_ready === 1'b1);
    if (ga) begin
      if (maskq.size() == 0) begin
        check("model_underflow", 32'd0, 32'd1);
        m = 1'b0;
      end else m = maskq.pop_front();
      expq.push_back(m ? dy : 8'h00);
    end
    if (fa) maskq.push_back(mask_of(x));
    @(posedge clk); #1;
    fwd_valid = 1'b0; grad_valid = 1'b0;
  endtask

  task automatic push_x(input logic [7:0] x);
    bit fa, ga;
    int n = 0;
    do begin cyc(1'b1, x, 1'b0, 8'h00, fa, ga); n++; end while (!fa && n < 20);
    if (!fa) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_dy(input logic [7:0] dy);
    bit fa, ga;
    int n = 0;
    do begin cyc(1'b0, 8'h00, 1'b1, dy, fa, ga); n++; end while (!ga && n < 20);
    if (!ga) check("grad_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    bit fa, ga;
    cyc(1'b0, 8'h00, 1'b0, 8'h00, fa, ga);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && dx_valid === 1'b1 && dx_ready === 1'b1) begin
      if (expq.size() == 0) check("dx_unexpected", 32'd1, 32'd0);
      else begin
        check("dx_data", 32'(dx), 32'(expq.pop_front()));
`ifdef RELU_BWD_SAT_EN
        check("sat_flag_n8", 32'(sat_flag), 32'd0);
`endif
      end
    end
  end

  initial begin
    bit fa, ga;
    rst = 1'b1; dx_ready = 1'b1;
    fwd_valid = 0; fwd_x = 0; grad_valid = 0; grad_in = 0;
    b_fwd_valid = 0; b_fwd_x = 0; b_grad_valid = 0; b_grad_in = 0; b_dx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_count", 32'(mask_count), 32'd0);
    check("rst_dx_valid", 32'(dx_valid), 32'd0);
    check("rst_dx", 32'(dx), 32'd0);
    check("rst_fwd_ready", 32'(fwd_ready), 32'd1);
    check("rst_grad_ready", 32'(grad_ready), 32'd0);
`ifdef RELU_BWD_SAT_EN
    check("rst_sat", 32'(sat_flag), 32'd0);
`endif
    @(posedge clk); #1;

    // Positive, negative and zero x.
    push_x(8'h20); push_x(8'hE0); push_x(8'h00);
    check("t1_count", 32'(mask_count), 32'd3);
    repeat (3) begin
      send_dy(8'h10);
      check("t1_latency", 32'(dx_valid), 32'd1);
    end
    idle();
    check("t1_drained", 32'(dx_valid), 32'd0);

    // Fill, blocked push, then simultaneous push and pop.
    push_x(8'h01); push_x(8'h02); push_x(8'h03); push_x(8'h04);
    check("t2_full_count", 32'(mask_count), 32'd4);
    check("t2_fwd_ready", 32'(fwd_ready), 32'd0);
    repeat (2) begin
      cyc(1'b1, 8'h05, 1'b0, 8'h00, fa, ga);
      check("t2_push_held", 32'(fa), 32'd0);
    end
    check("t2_count_held", 32'(mask_count), 32'd4);
    send_dy(8'h11); send_dy(8'h12);
    check("t2_count2", 32'(mask_count), 32'd2);
    cyc(1'b1, 8'h40, 1'b1, 8'h22, fa, ga);
    check("t2_pushpop_hs", 32'({fa, ga}), 32'd3);
    check("t2_pushpop_count", 32'(mask_count), 32'd2);
    send_dy(8'h33); send_dy(8'h44);
    idle();
    check("t2_empty", 32'(mask_count), 32'd0);

    // dy against an empty FIFO stalls.
    repeat (2) begin
      cyc(1'b0, 8'h00, 1'b1, 8'h10, fa, ga);
      check("t3_stall", 32'(ga), 32'd0);
      check("t3_no_dx", 32'(dx_valid), 32'd0);
    end
    cyc(1'b1, 8'h01, 1'b1, 8'h10, fa, ga);
    check("t3_push_only", 32'({fa, ga}), 32'd2);
    cyc(1'b0, 8'h00, 1'b1, 8'h10, fa, ga);
    check("t3_accept", 32'(ga), 32'd1);
    check("t3_dx_valid", 32'(dx_valid), 32'd1);
    idle();

    // Backpressure holds dx; release accepts the next dy in the same cycle.
    push_x(8'h01); push_x(8'h02);
    dx_ready = 1'b0;
    send_dy(8'h10);
    repeat (3) begin
      cyc(1'b0, 8'h00, 1'b1, 8'h30, fa, ga);
      check("t4_grad_stalled", 32'(ga), 32'd0);
      check("t4_hold_valid", 32'(dx_valid), 32'd1);
      check("t4_hold_dx", 32'(dx), 32'h10);
    end
    dx_ready = 1'b1;
    cyc(1'b0, 8'h00, 1'b1, 8'h30, fa, ga);
    check("t4_release_accept", 32'(ga), 32'd1);
    idle();

    // Reset mid-operation.
    push_x(8'h01); push_x(8'h01); push_x(8'h01);
    dx_ready = 1'b0;
    send_dy(8'h08);
    check("t6_pre_count", 32'(mask_count), 32'd2);
    check("t6_pre_valid", 32'(dx_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    maskq.delete(); expq.delete();
    check("t6_count", 32'(mask_count), 32'd0);
    check("t6_dx_valid", 32'(dx_valid), 32'd0);
    check("t6_fwd_ready", 32'(fwd_ready), 32'd1);
    dx_ready = 1'b1;
    push_x(8'h10);
    send_dy(8'hF0);
    idle();
    check("scoreboard_empty", 32'(expq.size()), 32'd0);

    // N=7 output: clamp or wrap of dy=0x7F.
    b_fwd_valid = 1'b1; b_fwd_x = 8'h01;
    @(negedge clk);
    check("n7_fwd_ready", 32'(b_fwd_ready), 32'd1);
    @(posedge clk); #1;
    b_fwd_valid = 1'b0; b_grad_valid = 1'b1; b_grad_in = 8'h7F;
    @(negedge clk);
    check("n7_grad_ready", 32'(b_grad_ready), 32'd1);
    @(posedge clk); #1;
    b_grad_valid = 1'b0;
    check("n7_dx_valid", 32'(b_dx_valid), 32'd1);
`ifdef RELU_BWD_SAT_EN
    check("n7_dx_sat", 32'(b_dx), 32'h3F);
    check("n7_sat_flag", 32'(b_sat_flag), 32'd1);
`else
    check("n7_dx_wrap", 32'(b_dx), 32'h7F);
`endif
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
